// File: rtl/frame_update_scheduler.sv
// Purpose : paces pong game-state updates to the VGA raster with a req/ack handshake to compute,
//           snapshotting ball/paddle positions into shadow registers the pixel generator reads.
// Latency : request rises 1 clk after end-of-active-frame; *_out update 2 clk after ack is sampled.
// Backpr. : compute_req held until ack or TIMEOUT_CYCLES; frames ending mid-update flag overrun.
// Build   : define FRAME_SCHED_FREEZE_EN to add the i_freeze input (blocks new requests in IDLE).
module frame_update_scheduler #(
  parameter int HSYNC_ACTIVE   = 639,
  parameter int VSYNC_ACTIVE   = 479,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_hcount,
  input  logic [9:0]  i_vcount,
  input  logic [1:0]  i_frame_div,
`ifdef FRAME_SCHED_FREEZE_EN
  input  logic        i_freeze,
`endif
  output logic        o_compute_req,
  input  logic        i_compute_ack,
  input  logic [31:0] i_ball_in,
  input  logic [31:0] i_lpad_in,
  input  logic [31:0] i_rpad_in,
  output logic [31:0] o_ball_out,
  output logic [31:0] o_lpad_out,
  output logic [31:0] o_rpad_out,
  output logic        o_snapshot_valid,
  output logic        o_busy,
  output logic        o_overrun_err,
  output logic        o_timeout_err,
  output logic [15:0] o_frame_count
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]     H_LAST  = 10'(HSYNC_ACTIVE);
  localparam logic [9:0]     V_LAST  = 10'(VSYNC_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_LATCH   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_eoa_q;
  logic [1:0]    r_div_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_req;
  logic          r_busy;
  logic          r_snapshot_valid;
  logic          r_overrun_err;
  logic          r_timeout_err;
  logic [15:0]   r_frame_count;
  logic [31:0]   r_ball_cap;
  logic [31:0]   r_lpad_cap;
  logic [31:0]   r_rpad_cap;
  logic [31:0]   r_ball_out;
  logic [31:0]   r_lpad_out;
  logic [31:0]   r_rpad_out;

  logic          w_eoa_lvl;
  logic          w_eoa;
  logic          w_freeze;

`ifdef FRAME_SCHED_FREEZE_EN
  assign w_freeze = i_freeze;
`else
  assign w_freeze = 1'b0;
`endif

  // A raster position held for several clocks must count as one frame end, hence the edge detect.
  assign w_eoa_lvl = (i_hcount == H_LAST) && (i_vcount == V_LAST);
  assign w_eoa     = w_eoa_lvl & ~r_eoa_q;

  // Remember last cycle's end-of-active level for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_eoa_q <= 1'b0;
    end else begin
      r_eoa_q <= w_eoa_lvl;
    end
  end

  // Update sequencer: frame divider, handshake with timeout, snapshot, sticky error flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state          <= ST_IDLE;
      r_div_cnt        <= 2'd0;
      r_tmo_cnt        <= '0;
      r_req            <= 1'b0;
      r_busy           <= 1'b0;
      r_snapshot_valid <= 1'b0;
      r_overrun_err    <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_frame_count    <= 16'd0;
      r_ball_cap       <= 32'd0;
      r_lpad_cap       <= 32'd0;
      r_rpad_cap       <= 32'd0;
      r_ball_out       <= 32'd0;
      r_lpad_out       <= 32'd0;
      r_rpad_out       <= 32'd0;
    end else begin
      r_snapshot_valid <= 1'b0;
      if (w_eoa) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      case (r_state)
        ST_IDLE: begin
          // frame_div is only looked at here, so a change applies from the next compare.
          if (w_eoa && !w_freeze) begin
            if (r_div_cnt == i_frame_div) begin
              r_div_cnt <= 2'd0;
              r_tmo_cnt <= '0;
              r_req     <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= ST_REQUEST;
            end else begin
              r_div_cnt <= r_div_cnt + 2'd1;
            end
          end
        end
        ST_REQUEST: begin
          if (w_eoa) begin
            r_overrun_err <= 1'b1;
          end
          // Ack is checked first so it wins over a simultaneous timeout.
          if (i_compute_ack) begin
            r_ball_cap <= i_ball_in;
            r_lpad_cap <= i_lpad_in;
            r_rpad_cap <= i_rpad_in;
            r_req      <= 1'b0;
            r_state    <= ST_LATCH;
          end else if (r_tmo_cnt == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_req         <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        ST_LATCH: begin
          if (w_eoa) begin
            r_overrun_err <= 1'b1;
          end
          r_ball_out       <= r_ball_cap;
          r_lpad_out       <= r_lpad_cap;
          r_rpad_out       <= r_rpad_cap;
          r_snapshot_valid <= 1'b1;
          r_busy           <= 1'b0;
          r_state          <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_compute_req    = r_req;
  assign o_busy           = r_busy;
  assign o_snapshot_valid = r_snapshot_valid;
  assign o_overrun_err    = r_overrun_err;
  assign o_timeout_err    = r_timeout_err;
  assign o_frame_count    = r_frame_count;
  assign o_ball_out       = r_ball_out;
  assign o_lpad_out       = r_lpad_out;
  assign o_rpad_out       = r_rpad_out;

endmodule
